// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select codes and the ID/EX control bundle layout.
package pipe_pkg;

  localparam int unsigned CTRL_W = 10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding select for one EX operand, resolved one cycle early from the producers that will
// occupy EX/MEM and MEM/WB when the consumer reaches EX.
module fwd_sel_calc
  import pipe_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic [RF_ADDR_W-1:0] i_src,
  input  logic [RF_ADDR_W-1:0] i_ex_dest,
  input  logic                 i_ex_reg_write,
  input  logic [RF_ADDR_W-1:0] i_mem_dest,
  input  logic                 i_mem_reg_write,
  output logic [1:0]           o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ex_reg_write && (i_ex_dest != '0) && (i_ex_dest == i_src);
  assign w_mem_hit = i_mem_reg_write && (i_mem_dest != '0) && (i_mem_dest == i_src);

  // The younger producer holds the most recent value, so it takes priority.
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit) begin
      o_sel = FWD_MEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with registered forwarding selects, load-use stall detection and a
// saturating stall counter.
module id_ex_forward_reg
  import pipe_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [RF_ADDR_W-1:0] ID_Rs,
  input  logic [RF_ADDR_W-1:0] ID_Rt,
  input  logic [RF_ADDR_W-1:0] ID_Rd,
  input  logic [DATA_W-1:0]    ID_ReadA,
  input  logic [DATA_W-1:0]    ID_ReadB,
  input  logic [DATA_W-1:0]    ID_Imm,
  input  logic [CTRL_W-1:0]    ID_Ctrl,
  input  logic [RF_ADDR_W-1:0] ExMem_Dest,
  input  logic                 ExMem_RegWrite,
  input  logic                 Flush,
  output logic [DATA_W-1:0]    EX_ReadA,
  output logic [DATA_W-1:0]    EX_ReadB,
  output logic [DATA_W-1:0]    EX_Imm,
  output logic [CTRL_W-1:0]    EX_Ctrl,
  output logic [RF_ADDR_W-1:0] EX_Dest,
  output logic [RF_ADDR_W-1:0] EX_Rt,
  output logic [1:0]           ForwardA,
  output logic [1:0]           ForwardB,
  output logic                 Stall,
  output logic [CNT_W-1:0]     StallCount
);

  logic [DATA_W-1:0]    r_read_a;
  logic [DATA_W-1:0]    r_read_b;
  logic [DATA_W-1:0]    r_imm;
  ctrl_t                r_ctrl;
  logic [RF_ADDR_W-1:0] r_dest;
  logic [RF_ADDR_W-1:0] r_rt;
  logic [1:0]           r_fwd_a;
  logic [1:0]           r_fwd_b;
  logic [CNT_W-1:0]     r_stall_count;

  ctrl_t                w_id_ctrl;
  logic [RF_ADDR_W-1:0] w_id_dest;
  logic [1:0]           w_fwd_a;
  logic [1:0]           w_fwd_b;
  logic                 w_hz;
  logic                 w_bubble;

  assign w_id_ctrl = ID_Ctrl;
  assign w_id_dest = w_id_ctrl.reg_dst ? ID_Rd : ID_Rt;

  assign w_hz = r_ctrl.mem_read && (r_dest != '0) && ((r_dest == ID_Rs) || (r_dest == ID_Rt));
  // A taken branch kills the consumer, so there is nothing to stall for.
  assign Stall    = w_hz && !Flush;
  assign w_bubble = Flush || Stall;

  fwd_sel_calc #(
    .RF_ADDR_W(RF_ADDR_W)
  ) u_fwd_a (
    .i_src          (ID_Rs),
    .i_ex_dest      (r_dest),
    .i_ex_reg_write (r_ctrl.reg_write),
    .i_mem_dest     (ExMem_Dest),
    .i_mem_reg_write(ExMem_RegWrite),
    .o_sel          (w_fwd_a)
  );

  fwd_sel_calc #(
    .RF_ADDR_W(RF_ADDR_W)
  ) u_fwd_b (
    .i_src          (ID_Rt),
    .i_ex_dest      (r_dest),
    .i_ex_reg_write (r_ctrl.reg_write),
    .i_mem_dest     (ExMem_Dest),
    .i_mem_reg_write(ExMem_RegWrite),
    .o_sel          (w_fwd_b)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_read_a      <= '0;
      r_read_b      <= '0;
      r_imm         <= '0;
      r_ctrl        <= '0;
      r_dest        <= '0;
      r_rt          <= '0;
      r_fwd_a       <= FWD_RF;
      r_fwd_b       <= FWD_RF;
      r_stall_count <= '0;
    end else begin
      r_read_a <= ID_ReadA;
      r_read_b <= ID_ReadB;
      r_imm    <= ID_Imm;
      r_rt     <= ID_Rt;
      if (w_bubble) begin
        r_ctrl  <= '0;
        r_dest  <= '0;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_ctrl  <= w_id_ctrl;
        r_dest  <= w_id_dest;
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
      if (Stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign EX_ReadA   = r_read_a;
  assign EX_ReadB   = r_read_b;
  assign EX_Imm     = r_imm;
  assign EX_Ctrl    = r_ctrl;
  assign EX_Dest    = r_dest;
  assign EX_Rt      = r_rt;
  assign ForwardA   = r_fwd_a;
  assign ForwardB   = r_fwd_b;
  assign StallCount = r_stall_count;

endmodule
